// File: rtl/trace_monitor_if.sv
// Trace drain port of trace_monitor: show-ahead head record plus valid/ready handshake.
interface trace_monitor_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);
    logic             trc_valid;
    logic             trc_ready;
    logic [XLEN-1:0]  trc_pc;
    logic [31:0]      trc_inst;
    logic [1:0]       trc_kind;
    logic             trc_jump;
    logic             trc_mem;
    logic [4:0]       trc_rd;
    logic [XLEN-1:0]  trc_data;
    logic [XLEN-1:0]  trc_addr;
    logic [CNT_W-1:0] trc_seq;

    modport master (
        output trc_valid, trc_pc, trc_inst, trc_kind, trc_jump, trc_mem,
               trc_rd, trc_data, trc_addr, trc_seq,
        input  trc_ready
    );

    modport slave (
        input  trc_valid, trc_pc, trc_inst, trc_kind, trc_jump, trc_mem,
               trc_rd, trc_data, trc_addr, trc_seq,
        output trc_ready
    );
endinterface

// File: rtl/trace_monitor.sv
// Retirement-trace monitor: realigns IF/EX/MEM taps to WB and buffers one record per retired slot.
// Optional: define TRACE_MONITOR_FLUSH_FILTER_EN to drop FLUSH records (they still consume a seq number).
module trace_monitor #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned STAGES  = 5,
    parameter int unsigned LAT_JMP = 2,
    parameter int unsigned LAT_MEM = 1,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     stall,
    input  logic                     if_valid,
    input  logic [XLEN-1:0]          pc,
    input  logic [31:0]              inst,
    input  logic                     is_jump,
    input  logic [XLEN-1:0]          jump_addr,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [XLEN-1:0]          mem_addr,
    input  logic [XLEN-1:0]          mem_data_w,
    input  logic                     flush,
    input  logic                     reg_wr,
    input  logic [4:0]               reg_addr_wr,
    input  logic [XLEN-1:0]          reg_data_wr,
    trace_monitor_if.master          trc,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         overflow_cnt
);

    localparam int unsigned PL    = STAGES - 1;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned REC_W = 3 * XLEN + 32 + 2 + 1 + 1 + 5 + CNT_W;

    typedef enum logic [1:0] {
        KIND_NONE  = 2'd0,
        KIND_REG   = 2'd1,
        KIND_STORE = 2'd2,
        KIND_FLUSH = 2'd3
    } kind_e;

    logic            pc_v   [PL];
    logic [XLEN-1:0] pc_d   [PL];
    logic [31:0]     inst_d [PL];
    logic            jmp_v  [LAT_JMP];
    logic [XLEN-1:0] jmp_a  [LAT_JMP];
    logic            mrd_d  [LAT_MEM];
    logic            mwr_d  [LAT_MEM];
    logic [XLEN-1:0] mad_d  [LAT_MEM];
    logic [XLEN-1:0] mdat_d [LAT_MEM];

    logic [REC_W-1:0] rec_mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] seq;
    logic [REC_W-1:0] head;
    logic             head_valid;

    kind_e            kind_c;
    logic             jump_c;
    logic             mem_c;
    logic [4:0]       rd_c;
    logic [XLEN-1:0]  data_c;
    logic [XLEN-1:0]  addr_c;
    logic [REC_W-1:0] rec_c;
    logic             formed_c;
    logic             keep_c;
    logic             accept_c;
    logic             pop_c;
    logic             full_c;
    logic             push_c;
    logic             drop_c;
    logic [AW-1:0]    rd_ptr_nxt_c;
    logic [CW-1:0]    count_nxt_c;
    logic [REC_W-1:0] head_nxt_c;

    // Stall-aware delay lines; entry slot 0 captures the tap, the last slot lines up with WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(PL); i++) begin
                pc_v[i]   <= 1'b0;
                pc_d[i]   <= '0;
                inst_d[i] <= '0;
            end
            for (int i = 0; i < int'(LAT_JMP); i++) begin
                jmp_v[i] <= 1'b0;
                jmp_a[i] <= '0;
            end
            for (int i = 0; i < int'(LAT_MEM); i++) begin
                mrd_d[i]  <= 1'b0;
                mwr_d[i]  <= 1'b0;
                mad_d[i]  <= '0;
                mdat_d[i] <= '0;
            end
        end else if (!stall) begin
            pc_v[0]   <= if_valid;
            pc_d[0]   <= pc;
            inst_d[0] <= inst;
            for (int i = 1; i < int'(PL); i++) begin
                pc_v[i]   <= pc_v[i-1];
                pc_d[i]   <= pc_d[i-1];
                inst_d[i] <= inst_d[i-1];
            end
            jmp_v[0] <= is_jump;
            jmp_a[0] <= jump_addr;
            for (int i = 1; i < int'(LAT_JMP); i++) begin
                jmp_v[i] <= jmp_v[i-1];
                jmp_a[i] <= jmp_a[i-1];
            end
            mrd_d[0]  <= mem_read;
            mwr_d[0]  <= mem_write;
            mad_d[0]  <= mem_addr;
            mdat_d[0] <= mem_data_w;
            for (int i = 1; i < int'(LAT_MEM); i++) begin
                mrd_d[i]  <= mrd_d[i-1];
                mwr_d[i]  <= mwr_d[i-1];
                mad_d[i]  <= mad_d[i-1];
                mdat_d[i] <= mdat_d[i-1];
            end
        end
    end

    // Record former: classify the retiring slot and pick its data/address fields.
    always_comb begin
        kind_c = KIND_NONE;
        rd_c   = '0;
        data_c = '0;
        jump_c = jmp_v[LAT_JMP-1];
        mem_c  = mrd_d[LAT_MEM-1] | mwr_d[LAT_MEM-1];
        addr_c = jump_c ? jmp_a[LAT_JMP-1] : (mem_c ? mad_d[LAT_MEM-1] : '0);
        if (reg_wr && (reg_addr_wr != 5'd0)) begin
            kind_c = KIND_REG;
            rd_c   = reg_addr_wr;
            data_c = reg_data_wr;
        end else if (mwr_d[LAT_MEM-1]) begin
            kind_c = KIND_STORE;
            data_c = mdat_d[LAT_MEM-1];
        end else if (flush) begin
            kind_c = KIND_FLUSH;
            jump_c = 1'b0;
            mem_c  = 1'b0;
            addr_c = '0;
        end
    end

    assign rec_c = {pc_d[PL-1], inst_d[PL-1], 2'(kind_c), jump_c, mem_c,
                    rd_c, data_c, addr_c, seq};

`ifdef TRACE_MONITOR_FLUSH_FILTER_EN
    assign keep_c = (kind_c != KIND_FLUSH);
`else
    assign keep_c = 1'b1;
`endif

    assign formed_c = !stall && pc_v[PL-1];
    assign accept_c = formed_c && enable;
    assign pop_c    = head_valid && trc.trc_ready;
    assign full_c   = (count == CW'(DEPTH));
    assign push_c   = accept_c && keep_c && (!full_c || pop_c);
    assign drop_c   = accept_c && keep_c && full_c && !pop_c;

    // Next head: bypass the incoming record when it lands in the slot that becomes head.
    always_comb begin
        rd_ptr_nxt_c = pop_c ? rd_ptr + AW'(1) : rd_ptr;
        count_nxt_c  = count;
        if (push_c && !pop_c) begin
            count_nxt_c = count + CW'(1);
        end else if (!push_c && pop_c) begin
            count_nxt_c = count - CW'(1);
        end
        head_nxt_c = '0;
        if (count_nxt_c != '0) begin
            if (push_c && (rd_ptr_nxt_c == wr_ptr)) begin
                head_nxt_c = rec_c;
            end else begin
                head_nxt_c = rec_mem[rd_ptr_nxt_c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            rec_mem[wr_ptr] <= rec_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            seq          <= '0;
            overflow_cnt <= '0;
            head         <= '0;
            head_valid   <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr     <= rd_ptr_nxt_c;
            count      <= count_nxt_c;
            head       <= head_nxt_c;
            head_valid <= (count_nxt_c != '0);
            if (accept_c) begin
                seq <= seq + CNT_W'(1);
            end
            if (drop_c && (overflow_cnt != '1)) begin
                overflow_cnt <= overflow_cnt + CNT_W'(1);
            end
        end
    end

    assign trc.trc_valid = head_valid;
    assign {trc.trc_pc, trc.trc_inst, trc.trc_kind, trc.trc_jump, trc.trc_mem,
            trc.trc_rd, trc.trc_data, trc.trc_addr, trc.trc_seq} = head;

endmodule

// File: tb/tb_trace_monitor.sv
// Directed bench for trace_monitor with a queue-based reference model checked every cycle.
module tb_trace_monitor;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned STAGES  = 5;
    localparam int unsigned LAT_JMP = 2;
    localparam int unsigned LAT_MEM = 1;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CNT_W   = 16;

`ifdef TRACE_MONITOR_FLUSH_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            enable, stall, if_valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            is_jump;
    logic [XLEN-1:0] jump_addr;
    logic            mem_read, mem_write;
    logic [XLEN-1:0] mem_addr, mem_data_w;
    logic            flush, reg_wr;
    logic [4:0]      reg_addr_wr;
    logic [XLEN-1:0] reg_data_wr;
    logic [$clog2(DEPTH):0] count;
    logic [CNT_W-1:0]       overflow_cnt;

    trace_monitor_if #(.XLEN(XLEN), .CNT_W(CNT_W)) trc ();

    trace_monitor #(
        .XLEN(XLEN), .STAGES(STAGES), .LAT_JMP(LAT_JMP), .LAT_MEM(LAT_MEM),
        .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .stall(stall), .if_valid(if_valid),
        .pc(pc), .inst(inst), .is_jump(is_jump), .jump_addr(jump_addr),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_data_w(mem_data_w), .flush(flush), .reg_wr(reg_wr),
        .reg_addr_wr(reg_addr_wr), .reg_data_wr(reg_data_wr), .trc(trc),
        .count(count), .overflow_cnt(overflow_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: history of captured taps per advance, plus a bounded record queue.
    typedef struct packed {
        logic        v;
        logic [31:0] pc, inst;
        logic        j;
        logic [31:0] ja;
        logic        mr, mw;
        logic [31:0] ma, md;
    } tap_t;

    typedef struct packed {
        logic [31:0] pc, inst;
        logic [1:0]  kind;
        logic        jump, mem;
        logic [4:0]  rd;
        logic [31:0] data, addr;
        logic [15:0] seq;
    } rec_t;

    tap_t        hist[$];
    rec_t        q[$];
    logic [15:0] mseq;
    logic [15:0] movf;

    always @(posedge clk or posedge rst) begin : model
        tap_t tp, tj, tm, cur;
        rec_t r;
        bit   formed, pop, full;
        if (rst) begin
            hist.delete();
            q.delete();
            mseq = '0;
            movf = '0;
        end else begin
            formed = 1'b0;
            r      = '0;
            full   = (q.size() == int'(DEPTH));
            pop    = (q.size() != 0) && trc.trc_ready;
            if (!stall) begin
                if (hist.size() >= int'(STAGES - 1) && hist[STAGES-2].v) begin
                    tp = hist[STAGES-2];
                    tj = hist[LAT_JMP-1];
                    tm = hist[LAT_MEM-1];
                    formed = 1'b1;
                    r.pc   = tp.pc;
                    r.inst = tp.inst;
                    r.jump = tj.j;
                    r.mem  = tm.mr | tm.mw;
                    r.addr = tj.j ? tj.ja : (r.mem ? tm.ma : 32'd0);
                    if (reg_wr && reg_addr_wr != 5'd0) begin
                        r.kind = 2'd1; r.rd = reg_addr_wr; r.data = reg_data_wr;
                    end else if (tm.mw) begin
                        r.kind = 2'd2; r.data = tm.md;
                    end else if (flush) begin
                        r.kind = 2'd3; r.jump = 1'b0; r.mem = 1'b0; r.addr = 32'd0;
                    end
                    r.seq = mseq;
                end
                cur.v = if_valid; cur.pc = pc; cur.inst = inst;
                cur.j = is_jump; cur.ja = jump_addr;
                cur.mr = mem_read; cur.mw = mem_write;
                cur.ma = mem_addr; cur.md = mem_data_w;
                hist.push_front(cur);
                if (hist.size() > 8) void'(hist.pop_back());
            end
            if (pop) void'(q.pop_front());
            if (formed && enable) begin
                mseq = mseq + 16'd1;
                if (!(FILT && r.kind == 2'd3)) begin
                    if (!full || pop) q.push_back(r);
                    else if (movf != 16'hFFFF) movf = movf + 16'd1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("valid", trc.trc_valid, q.size() != 0);
            chk("count", count, q.size());
            chk("overflow", overflow_cnt, movf);
            if (q.size() != 0) begin
                chk("pc", trc.trc_pc, q[0].pc);
                chk("inst", trc.trc_inst, q[0].inst);
                chk("kind", trc.trc_kind, q[0].kind);
                chk("jump", trc.trc_jump, q[0].jump);
                chk("mem", trc.trc_mem, q[0].mem);
                chk("rd", trc.trc_rd, q[0].rd);
                chk("data", trc.trc_data, q[0].data);
                chk("addr", trc.trc_addr, q[0].addr);
                chk("seq", trc.trc_seq, q[0].seq);
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic issue(input logic [31:0] p, input logic [31:0] i);
        if_valid = 1'b1; pc = p; inst = i;
        cyc();
        if_valid = 1'b0;
    endtask

    task automatic wb_reg(input logic [4:0] rd, input logic [31:0] d);
        reg_wr = 1'b1; reg_addr_wr = rd; reg_data_wr = d;
    endtask

    task automatic wb_clear();
        reg_wr = 1'b0; reg_addr_wr = '0; reg_data_wr = '0; flush = 1'b0;
    endtask

    task automatic drain_one();
        trc.trc_ready = 1'b1;
        cyc();
        trc.trc_ready = 1'b0;
    endtask

    initial begin
        enable = 1'b1; stall = 1'b0; if_valid = 1'b0; pc = '0; inst = '0;
        is_jump = 1'b0; jump_addr = '0; mem_read = 1'b0; mem_write = 1'b0;
        mem_addr = '0; mem_data_w = '0; flush = 1'b0; reg_wr = 1'b0;
        reg_addr_wr = '0; reg_data_wr = '0; trc.trc_ready = 1'b0;

        #1 rst = 1'b1;
        cyc(2);
        chk("rst_valid", trc.trc_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_seq", trc.trc_seq, 0);
        rst = 1'b0;

        // Single REG retirement, 5 advances end to end
        issue(32'h100, 32'h02A00293);
        cyc(3);
        wb_reg(5'd5, 32'h2A);
        cyc();
        wb_clear();
        @(negedge clk);
        chk("t2_valid", trc.trc_valid, 1);
        chk("t2_pc", trc.trc_pc, 32'h100);
        chk("t2_inst", trc.trc_inst, 32'h02A00293);
        chk("t2_kind", trc.trc_kind, 1);
        chk("t2_rd", trc.trc_rd, 5);
        chk("t2_data", trc.trc_data, 32'h2A);
        chk("t2_seq", trc.trc_seq, 0);
        drain_one();

        // Same with a 3-cycle stall in flight
        issue(32'h300, 32'h00100093);
        cyc();
        stall = 1'b1;
        cyc(3);
        stall = 1'b0;
        cyc(2);
        @(negedge clk);
        chk("t3_early", trc.trc_valid, 0);
        wb_reg(5'd1, 32'h1);
        cyc();
        wb_clear();
        @(negedge clk);
        chk("t3_pc", trc.trc_pc, 32'h300);
        chk("t3_seq", trc.trc_seq, 1);
        cyc(3);
        chk("t3_nodup", count, 1);
        drain_one();

        // Store at MEM followed by a jump at EX
        issue(32'h200, 32'h00A12023);
        if_valid = 1'b1; pc = 32'h204; inst = 32'h0400006F;
        cyc();
        if_valid = 1'b0;
        cyc();
        mem_write = 1'b1; mem_addr = 32'h8000; mem_data_w = 32'hDEADBEEF;
        is_jump = 1'b1; jump_addr = 32'h40;
        cyc();
        mem_write = 1'b0; mem_addr = '0; mem_data_w = '0; is_jump = 1'b0; jump_addr = '0;
        cyc();
        @(negedge clk);
        chk("t4_kind", trc.trc_kind, 2);
        chk("t4_mem", trc.trc_mem, 1);
        chk("t4_addr", trc.trc_addr, 32'h8000);
        chk("t4_data", trc.trc_data, 32'hDEADBEEF);
        chk("t4_seq", trc.trc_seq, 2);
        drain_one();
        @(negedge clk);
        chk("t4j_pc", trc.trc_pc, 32'h204);
        chk("t4j_jump", trc.trc_jump, 1);
        chk("t4j_addr", trc.trc_addr, 32'h40);
        chk("t4j_seq", trc.trc_seq, 3);
        drain_one();

        // Flushed slot between two REG retirements
        issue(32'h400, 32'h00300193);
        issue(32'h404, 32'h00000013);
        issue(32'h408, 32'h00400213);
        cyc();
        wb_reg(5'd3, 32'h11);
        cyc();
        wb_clear(); flush = 1'b1;
        cyc();
        flush = 1'b0; wb_reg(5'd4, 32'h22);
        cyc();
        wb_clear();
        @(negedge clk);
        chk("t6_seq0", trc.trc_seq, 4);
        chk("t6_kind0", trc.trc_kind, 1);
        if (!FILT) begin
            chk("t6_count", count, 3);
            drain_one();
            @(negedge clk);
            chk("t6_seq1", trc.trc_seq, 5);
            chk("t6_kind1", trc.trc_kind, 3);
            chk("t6_data1", trc.trc_data, 0);
        end else begin
            chk("t6_count", count, 2);
        end
        drain_one();
        @(negedge clk);
        chk("t6_seq2", trc.trc_seq, 6);
        chk("t6_kind2", trc.trc_kind, 1);
        chk("t6_rd2", trc.trc_rd, 4);
        drain_one();

        rst = 1'b1;
        cyc();
        rst = 1'b0;

        // Overflow: 6 records into a 4-entry buffer
        for (int k = 0; k < 6; k++) issue(32'h1000 + 32'(4 * k), 32'h13);
        cyc(4);
        @(negedge clk);
        chk("t5_count", count, 4);
        chk("t5_ovf", overflow_cnt, 2);
        trc.trc_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t5_drain_seq", trc.trc_seq, i);
            cyc();
            @(negedge clk);
        end
        trc.trc_ready = 1'b0;
        chk("t5_empty", trc.trc_valid, 0);
        enable = 1'b0;
        issue(32'h2000, 32'h13);
        cyc(4);
        enable = 1'b1;
        issue(32'h2004, 32'h13);
        cyc(4);
        @(negedge clk);
        chk("t5_next_seq", trc.trc_seq, 6);
        chk("t5_next_pc", trc.trc_pc, 32'h2004);
        for (int k = 0; k < 4; k++) issue(32'h3000 + 32'(4 * k), 32'h13);
        cyc(3);
        trc.trc_ready = 1'b1;
        cyc();
        trc.trc_ready = 1'b0;
        @(negedge clk);
        chk("t5_fullpop_count", count, 4);
        chk("t5_fullpop_ovf", overflow_cnt, 2);
        chk("t5_fullpop_seq", trc.trc_seq, 7);

        // Asynchronous reset mid-drain with 3 records buffered
        drain_one();
        @(negedge clk);
        chk("t1_pre_count", count, 3);
        cyc();
        rst = 1'b1;
        #1;
        chk("t1_count", count, 0);
        chk("t1_valid", trc.trc_valid, 0);
        chk("t1_seq", trc.trc_seq, 0);
        chk("t1_ovf", overflow_cnt, 0);
        chk("t1_pc", trc.trc_pc, 0);
        cyc();
        rst = 1'b0;
        issue(32'h5000, 32'h13);
        cyc(4);
        @(negedge clk);
        chk("t1_after_seq", trc.trc_seq, 0);
        chk("t1_after_count", count, 1);
        drain_one();
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
